matmul_seq_ctrl: RTL and testbench

Top-level sequencer for the coefficient-by-input-matrix MAC datapath. It accepts a start command and loads the 8x8 byte input matrix into the shift buffer through a valid/ready stream. It then enables the ALU for one compute pass, routes the ALU result-write strobes to the result RAM with generated addresses, and reports done or timeout. It sits between the host/testbench interface and the input buffer, coefficient ROM, ALU and result RAM.

---
 rtl/matmul_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the matrix MAC datapath: streams the 8x8 input matrix into the
// shift buffer, runs one ALU pass and steers its result writes into the result RAM.
module matmul_seq_ctrl #(
    parameter int LOAD_BEATS = 16,
    parameter int RES_WORDS  = 4,
    parameter int TIMEOUT    = 64,
    parameter int AW         = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          buf_we,
    output logic [3:0]    buf_addr,
    output logic          buf_rewind,
    output logic          alu_en,
    input  logic          alu_web,
    input  logic          alu_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]      LAST_BEAT = 4'(LOAD_BEATS - 1);
    localparam logic [AW:0]     WR_LIMIT  = (AW + 1)'(RES_WORDS);
    localparam logic [TW-1:0]   CYC_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REWIND,
        S_COMPUTE,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    // One bit wider than ram_addr so a full result set is distinguishable from zero.
    logic [AW:0]   wr_cnt;
    logic [TW-1:0] cyc_cnt;
    logic          wr_full;

    assign wr_full  = (wr_cnt == WR_LIMIT);
    assign ram_addr = wr_cnt[AW-1:0];

    // Write strobes are qualified combinationally so the accepting cycle is the strobe cycle.
    assign buf_we = in_valid & in_ready;
    assign ram_we = alu_web & alu_en & (state == S_COMPUTE) & ~wr_full;

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            buf_addr   <= '0;
            buf_rewind <= 1'b0;
            alu_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wr_cnt     <= '0;
            cyc_cnt    <= '0;
        end else begin
            buf_rewind <= 1'b0;
            done       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        buf_addr <= '0;
                        wr_cnt   <= '0;
                    end
                end

                S_LOAD: begin
                    if (buf_we) begin
                        if (buf_addr == LAST_BEAT) begin
                            state      <= S_REWIND;
                            in_ready   <= 1'b0;
                            buf_rewind <= 1'b1;
                        end else begin
                            buf_addr <= buf_addr + 4'd1;
                        end
                    end
                end

                S_REWIND: begin
                    state   <= S_COMPUTE;
                    alu_en  <= 1'b1;
                    cyc_cnt <= '0;
                end

                S_COMPUTE: begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                    if (alu_web && wr_full) begin
                        state  <= S_ERROR;
                        alu_en <= 1'b0;
                        err    <= 1'b1;
                    end else if (alu_web && alu_done) begin
                        state  <= S_DRAIN;
                        alu_en <= 1'b0;
                        wr_cnt <= wr_cnt + 1'b1;
                    end else begin
                        if (alu_web) begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                        if (cyc_cnt == CYC_LIMIT) begin
                            state  <= S_ERROR;
                            alu_en <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                end

                // The idle ALU cycle here lets it clear its accumulators.
                S_DRAIN: begin
                    if (wr_cnt == WR_LIMIT) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                S_ERROR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    alu_en   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: randomized input stalls and a cycle-counting
// ALU model, checked against the expected beat/write sequences and pass latencies.
module tb_matmul_seq_ctrl;

    localparam int LOAD_BEATS = 16;
    localparam int RES_WORDS  = 4;
    localparam int TIMEOUT    = 64;
    localparam int AW         = 2;
    localparam int WAIT_LIMIT = 400;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic          alu_web  = 1'b0;
    logic          alu_done = 1'b0;
    logic          in_ready, buf_we, buf_rewind, alu_en, ram_we, busy, done, err;
    logic [3:0]    buf_addr;
    logic [AW-1:0] ram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    matmul_seq_ctrl #(
        .LOAD_BEATS(LOAD_BEATS),
        .RES_WORDS (RES_WORDS),
        .TIMEOUT   (TIMEOUT),
        .AW        (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_rewind(buf_rewind),
        .alu_en    (alu_en),
        .alu_web   (alu_web),
        .alu_done  (alu_done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Event log sampled on the falling edge, away from the active edge.
    int cyc = 0;
    int q_buf[$];
    int q_ram[$];
    int q_done[$];
    int q_start[$];
    int q_err[$];
    int n_rewind = 0;
    int n_ready  = 0;
    bit err_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (buf_we)                 q_buf.push_back(int'(buf_addr));
        if (ram_we)                 q_ram.push_back(int'(ram_addr));
        if (done)                   q_done.push_back(cyc);
        if (start && !busy && rst)  q_start.push_back(cyc);
        if (err && !err_prev)       q_err.push_back(cyc);
        err_prev = err;
        if (buf_rewind)             n_rewind++;
        if (in_ready)               n_ready++;
    end

    typedef struct {
        int nb, nr, nd, ns, ne, nrw, nrd;
    } snap_t;

    function automatic snap_t take_snap();
        snap_t s;
        s.nb  = q_buf.size();
        s.nr  = q_ram.size();
        s.nd  = q_done.size();
        s.ns  = q_start.size();
        s.ne  = q_err.size();
        s.nrw = n_rewind;
        s.nrd = n_ready;
        return s;
    endfunction

    // ALU model: a write strobe after every 8th enabled edge, up to alu_pulses strobes,
    // alu_done on strobe number alu_done_on (0 = never).
    int alu_pulses  = 4;
    int alu_done_on = 4;
    bit spur_web    = 1'b0;

    initial begin : alu_model
        bit en_s;
        int edges;
        int pulses;
        en_s   = 1'b0;
        edges  = 0;
        pulses = 0;
        forever begin
            @(negedge clk);
            en_s = alu_en;
            @(posedge clk);
            #1;
            if (en_s) begin
                edges++;
                if (edges % 8 == 0 && pulses < alu_pulses) begin
                    pulses++;
                    alu_web  = 1'b1;
                    alu_done = (pulses == alu_done_on);
                end else begin
                    alu_web  = 1'b0;
                    alu_done = 1'b0;
                end
            end else begin
                edges    = 0;
                pulses   = 0;
                alu_web  = (spur_web && !alu_en) ? 1'($urandom_range(0, 1)) : 1'b0;
                alu_done = (spur_web && !alu_en) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives LOAD_BEATS beats: mode 0 back-to-back, 1 every other cycle, 2 random gaps.
    // lc returns how many LOAD cycles that took.
    task automatic feed(input int mode, input bit start_mid, output int lc);
        int  beats;
        bit  v;
        beats = 0;
        lc    = 0;
        while (beats < LOAD_BEATS && lc < 500) begin
            v        = (mode == 0) ? 1'b1 : (mode == 1) ? (lc % 2 == 1) : ($urandom_range(0, 3) != 0);
            in_valid = v;
            start    = start_mid && (lc == 2);
            lc++;
            if (v) beats++;
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_pass(input int mode, input bit start_mid, output int lc, output bit ok);
        do_start();
        feed(mode, start_mid, lc);
        if (mode == 2) in_valid = 1'($urandom_range(0, 1));
        if (start_mid) begin
            repeat (6) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_idle(ok);
        in_valid = 1'b0;
        tick();
    endtask

    function automatic int latency(snap_t sn, bit use_err);
        if (q_start.size() != sn.ns + 1) return -1;
        if (use_err) return (q_err.size() == sn.ne + 1) ? q_err[sn.ne] - q_start[sn.ns] : -1;
        return (q_done.size() == sn.nd + 1) ? q_done[sn.nd] - q_start[sn.ns] : -1;
    endfunction

    task automatic test_reset();
        logic [11+AW:0] outs;
        snap_t sn;
        rst      = 1'b0;
        in_valid = 1'b1;
        spur_web = 1'b1;
        repeat (3) tick();
        outs = {in_ready, buf_we, buf_addr, buf_rewind, alu_en, ram_we, ram_addr, busy, done, err};
        n_tests++;
        if (outs !== '0) begin
            $display("FAIL reset_outputs: got %b expected all zero", outs);
            n_fail++;
        end
        rst = 1'b1;
        sn  = take_snap();
        repeat (6) tick();
        n_tests++;
        if ({in_ready, busy, alu_en, err} !== 4'b0) begin
            $display("FAIL idle_outputs: got %b expected 0000", {in_ready, busy, alu_en, err});
            n_fail++;
        end
        n_tests++;
        if (q_buf.size() - sn.nb != 0 || q_ram.size() - sn.nr != 0) begin
            $display("FAIL idle_strobes: got buf_we %0d ram_we %0d expected 0 0",
                     q_buf.size() - sn.nb, q_ram.size() - sn.nr);
            n_fail++;
        end
        in_valid = 1'b0;
        spur_web = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        snap_t sn;
        int    lc, lat, bad;
        bit    ok;
        alu_pulses  = 4;
        alu_done_on = 4;
        sn = take_snap();
        run_pass(0, 1'b0, lc, ok);
        n_tests++;
        if (!ok) begin
            $display("FAIL nominal_finish: got busy after %0d cycles expected idle", WAIT_LIMIT);
            n_fail++;
        end
        bad = -1;
        for (int i = 0; i < LOAD_BEATS; i++)
            if (bad < 0 && (sn.nb + i >= q_buf.size() || q_buf[sn.nb + i] != i)) bad = i;
        n_tests++;
        if (bad >= 0 || q_buf.size() - sn.nb != LOAD_BEATS) begin
            $display("FAIL nominal_buf_addr: got %0d beats first bad index %0d expected 0..%0d",
                     q_buf.size() - sn.nb, bad, LOAD_BEATS - 1);
            n_fail++;
        end
        n_tests++;
        if (n_rewind - sn.nrw != 1) begin
            $display("FAIL nominal_rewind: got %0d pulses expected 1", n_rewind - sn.nrw);
            n_fail++;
        end
        bad = -1;
        for (int i = 0; i < RES_WORDS; i++)
            if (bad < 0 && (sn.nr + i >= q_ram.size() || q_ram[sn.nr + i] != i)) bad = i;
        n_tests++;
        if (bad >= 0 || q_ram.size() - sn.nr != RES_WORDS) begin
            $display("FAIL nominal_ram_addr: got %0d writes first bad index %0d expected 0..%0d",
                     q_ram.size() - sn.nr, bad, RES_WORDS - 1);
            n_fail++;
        end
        lat = latency(sn, 1'b0);
        n_tests++;
        if (lat != lc + (8 * alu_done_on + 1) + 3) begin
            $display("FAIL nominal_latency: got %0d expected %0d", lat, lc + (8 * alu_done_on + 1) + 3);
            n_fail++;
        end
        n_tests++;
        if (err !== 1'b0 || n_ready - sn.nrd != lc) begin
            $display("FAIL nominal_err_ready: got err %b ready %0d expected err 0 ready %0d",
                     err, n_ready - sn.nrd, lc);
            n_fail++;
        end
    endtask

    task automatic test_stalls();
        snap_t sn;
        int    lc, lat, bad, mode;
        bit    ok;
        alu_pulses  = 4;
        alu_done_on = 4;
        for (int r = 0; r < 3; r++) begin
            mode = (r == 0) ? 1 : 2;
            sn   = take_snap();
            run_pass(mode, 1'b0, lc, ok);
            bad = -1;
            for (int i = 0; i < LOAD_BEATS; i++)
                if (bad < 0 && (sn.nb + i >= q_buf.size() || q_buf[sn.nb + i] != i)) bad = i;
            n_tests++;
            if (!ok || bad >= 0 || q_buf.size() - sn.nb != LOAD_BEATS) begin
                $display("FAIL stall_beats_m%0d: got ok %b beats %0d bad index %0d expected %0d in order",
                         mode, ok, q_buf.size() - sn.nb, bad, LOAD_BEATS);
                n_fail++;
            end
            lat = latency(sn, 1'b0);
            n_tests++;
            if (lat != lc + (8 * alu_done_on + 1) + 3 || err !== 1'b0) begin
                $display("FAIL stall_latency_m%0d: got %0d err %b expected %0d err 0",
                         mode, lat, err, lc + (8 * alu_done_on + 1) + 3);
                n_fail++;
            end
            n_tests++;
            if (n_ready - sn.nrd != lc) begin
                $display("FAIL stall_ready_m%0d: got %0d ready cycles expected %0d", mode, n_ready - sn.nrd, lc);
                n_fail++;
            end
        end
    endtask

    task automatic test_timeout();
        snap_t sn;
        int    lc, lat;
        bit    ok;
        alu_pulses  = 4;
        alu_done_on = 0;
        sn = take_snap();
        run_pass(2, 1'b0, lc, ok);
        n_tests++;
        if (!ok || q_done.size() - sn.nd != 0) begin
            $display("FAIL timeout_no_done: got ok %b done %0d expected 1 0", ok, q_done.size() - sn.nd);
            n_fail++;
        end
        n_tests++;
        if ({err, alu_en, busy} !== 3'b100) begin
            $display("FAIL timeout_flags: got err/alu_en/busy %b expected 100", {err, alu_en, busy});
            n_fail++;
        end
        lat = latency(sn, 1'b1);
        n_tests++;
        if (lat != lc + TIMEOUT + 2) begin
            $display("FAIL timeout_cycle: got %0d expected %0d", lat, lc + TIMEOUT + 2);
            n_fail++;
        end
    endtask

    task automatic test_err_clear();
        snap_t sn;
        int    lc;
        bit    ok;
        alu_pulses  = 4;
        alu_done_on = 4;
        repeat (3) tick();
        n_tests++;
        if (err !== 1'b1) begin
            $display("FAIL err_sticky: got %b expected 1", err);
            n_fail++;
        end
        sn = take_snap();
        do_start();
        n_tests++;
        if (err !== 1'b0) begin
            $display("FAIL err_clear_on_start: got %b expected 0", err);
            n_fail++;
        end
        feed(0, 1'b0, lc);
        wait_idle(ok);
        tick();
        n_tests++;
        if (!ok || q_done.size() - sn.nd != 1 || err !== 1'b0) begin
            $display("FAIL err_clear_pass: got ok %b done %0d err %b expected 1 1 0",
                     ok, q_done.size() - sn.nd, err);
            n_fail++;
        end
    endtask

    task automatic test_write_count(input int pulses, input int done_on, input int exp_writes,
                                    input int exp_err_lat, input string tag);
        snap_t sn;
        int    lc, lat;
        bit    ok;
        alu_pulses  = pulses;
        alu_done_on = done_on;
        sn = take_snap();
        run_pass(0, 1'b0, lc, ok);
        n_tests++;
        if (q_ram.size() - sn.nr != exp_writes || q_done.size() - sn.nd != 0) begin
            $display("FAIL %s_writes: got %0d writes %0d done expected %0d writes 0 done",
                     tag, q_ram.size() - sn.nr, q_done.size() - sn.nd, exp_writes);
            n_fail++;
        end
        lat = latency(sn, 1'b1);
        n_tests++;
        if (!ok || err !== 1'b1 || lat != lc + exp_err_lat) begin
            $display("FAIL %s_err: got ok %b err %b at %0d expected err 1 at %0d",
                     tag, ok, err, lat, lc + exp_err_lat);
            n_fail++;
        end
    endtask

    task automatic test_start_busy();
        snap_t sn;
        int    lc, lat, bad;
        bit    ok;
        alu_pulses  = 4;
        alu_done_on = 4;
        spur_web    = 1'b1;
        sn = take_snap();
        repeat (5) tick();
        run_pass(0, 1'b1, lc, ok);
        spur_web = 1'b0;
        n_tests++;
        if (!ok || q_start.size() - sn.ns != 1) begin
            $display("FAIL busy_start_ignored: got ok %b accepted starts %0d expected 1 1",
                     ok, q_start.size() - sn.ns);
            n_fail++;
        end
        bad = -1;
        for (int i = 0; i < RES_WORDS; i++)
            if (bad < 0 && (sn.nr + i >= q_ram.size() || q_ram[sn.nr + i] != i)) bad = i;
        n_tests++;
        if (bad >= 0 || q_ram.size() - sn.nr != RES_WORDS) begin
            $display("FAIL busy_spurious_web: got %0d writes bad index %0d expected %0d",
                     q_ram.size() - sn.nr, bad, RES_WORDS);
            n_fail++;
        end
        lat = latency(sn, 1'b0);
        n_tests++;
        if (lat != lc + (8 * alu_done_on + 1) + 3 || err !== 1'b0) begin
            $display("FAIL busy_done: got latency %0d err %b expected %0d err 0",
                     lat, err, lc + (8 * alu_done_on + 1) + 3);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [11+AW:0] outs;
        snap_t sn;
        int    lc, bad;
        bit    ok;
        alu_pulses  = 4;
        alu_done_on = 4;
        sn = take_snap();
        do_start();
        feed(0, 1'b0, lc);
        repeat (10) tick();
        n_tests++;
        if (alu_en !== 1'b1) begin
            $display("FAIL midreset_precond: got alu_en %b expected 1", alu_en);
            n_fail++;
        end
        #2 rst = 1'b0;
        #1;
        outs = {in_ready, buf_we, buf_addr, buf_rewind, alu_en, ram_we, ram_addr, busy, done, err};
        n_tests++;
        if (outs !== '0) begin
            $display("FAIL midreset_outputs: got %b expected all zero", outs);
            n_fail++;
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (q_done.size() - sn.nd != 0) begin
            $display("FAIL midreset_no_done: got %0d expected 0", q_done.size() - sn.nd);
            n_fail++;
        end
        sn = take_snap();
        run_pass(0, 1'b0, lc, ok);
        bad = -1;
        for (int i = 0; i < RES_WORDS; i++)
            if (bad < 0 && (sn.nr + i >= q_ram.size() || q_ram[sn.nr + i] != i)) bad = i;
        n_tests++;
        if (!ok || bad >= 0 || q_ram.size() - sn.nr != RES_WORDS || q_done.size() - sn.nd != 1) begin
            $display("FAIL midreset_rerun: got ok %b writes %0d bad index %0d done %0d expected 1 %0d -1 1",
                     ok, q_ram.size() - sn.nr, bad, q_done.size() - sn.nd, RES_WORDS);
            n_fail++;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no summary expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_nominal();
        test_stalls();
        test_timeout();
        test_err_clear();
        test_write_count(5, 6, RES_WORDS, (8 * 5 + 1) + 2, "extra_write");
        test_write_count(3, 3, 3, (8 * 3 + 1) + 3, "short_write");
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
